// File: rtl/subservient_ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port 8-bit RAM, with a
// zero-fill sweep that runs after reset release and on request.
module subservient_ram_arbiter #(
  parameter int unsigned depth          = 256,
  parameter int unsigned aw             = $clog2(depth),
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_a_req,
  input  logic          i_a_we,
  input  logic [aw-1:0] i_a_addr,
  input  logic [7:0]    i_a_wdata,
  output logic          o_a_gnt,
  output logic          o_a_rvalid,
  output logic [7:0]    o_a_rdata,
  input  logic          i_b_req,
  input  logic          i_b_we,
  input  logic [aw-1:0] i_b_addr,
  input  logic [7:0]    i_b_wdata,
  output logic          o_b_gnt,
  output logic          o_b_rvalid,
  output logic [7:0]    o_b_rdata,
  input  logic          i_clear,
  output logic          o_busy,
  output logic [aw-1:0] o_ram_waddr,
  output logic [aw-1:0] o_ram_raddr,
  output logic [7:0]    o_ram_wdata,
  output logic          o_ram_wen,
  output logic          o_ram_ren,
  input  logic [7:0]    i_ram_rdata
);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  localparam logic [aw-1:0] LastAddr   = aw'(depth - 1);
  localparam state_e        ResetState = CLEAR_ON_RESET ? StClear : StRun;

  state_e        state_q, state_d;
  logic [aw-1:0] cnt_q, cnt_d;
  logic          prio_b_q, prio_b_d;  // 1: B wins when both request
  logic          a_rv_q, a_rv_d;
  logic          b_rv_q, b_rv_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ResetState;
      cnt_q    <= '0;
      prio_b_q <= 1'b0;
      a_rv_q   <= 1'b0;
      b_rv_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prio_b_q <= prio_b_d;
      a_rv_q   <= a_rv_d;
      b_rv_q   <= b_rv_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prio_b_d    = prio_b_q;
    a_rv_d      = 1'b0;
    b_rv_d      = 1'b0;
    o_a_gnt     = 1'b0;
    o_b_gnt     = 1'b0;
    o_busy      = 1'b0;
    o_ram_wen   = 1'b0;
    o_ram_ren   = 1'b0;
    o_ram_waddr = '0;
    o_ram_raddr = '0;
    o_ram_wdata = 8'h00;
    unique case (state_q)
      StClear: begin
        o_busy      = 1'b1;
        o_ram_wen   = 1'b1;
        o_ram_waddr = cnt_q;
        if (cnt_q == LastAddr) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        o_a_gnt = i_a_req & (~i_b_req | ~prio_b_q);
        o_b_gnt = i_b_req & ~o_a_gnt;
        if (o_a_gnt) begin
          prio_b_d = 1'b1;
          if (i_a_we) begin
            o_ram_wen   = 1'b1;
            o_ram_waddr = i_a_addr;
            o_ram_wdata = i_a_wdata;
          end else begin
            o_ram_ren   = 1'b1;
            o_ram_raddr = i_a_addr;
            a_rv_d      = 1'b1;
          end
        end else if (o_b_gnt) begin
          prio_b_d = 1'b0;
          if (i_b_we) begin
            o_ram_wen   = 1'b1;
            o_ram_waddr = i_b_addr;
            o_ram_wdata = i_b_wdata;
          end else begin
            o_ram_ren   = 1'b1;
            o_ram_raddr = i_b_addr;
            b_rv_d      = 1'b1;
          end
        end
        if (i_clear) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      default: state_d = StRun;
    endcase
    // Outputs read as zero for the whole time reset is held, not just after an edge.
    if (!i_rst_n) begin
      o_a_gnt     = 1'b0;
      o_b_gnt     = 1'b0;
      o_busy      = 1'b0;
      o_ram_wen   = 1'b0;
      o_ram_ren   = 1'b0;
      o_ram_waddr = '0;
      o_ram_raddr = '0;
      o_ram_wdata = 8'h00;
    end
  end

  assign o_a_rvalid = a_rv_q;
  assign o_b_rvalid = b_rv_q;
  assign o_a_rdata  = a_rv_q ? i_ram_rdata : 8'h00;
  assign o_b_rdata  = b_rv_q ? i_ram_rdata : 8'h00;

endmodule

// File: tb/tb_subservient_ram_arbiter.sv
// Bench for subservient_ram_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level model with its own shadow memory.
module tb_subservient_ram_arbiter;

  localparam int Depth = 256;
  localparam int Aw    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, clear;
  logic          a_req, a_we, b_req, b_we;
  logic [Aw-1:0] a_addr, b_addr;
  logic [7:0]    a_wdata, b_wdata;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid, busy;
  logic [7:0]    a_rdata, b_rdata;
  logic [Aw-1:0] ram_waddr, ram_raddr;
  logic [7:0]    ram_wdata, ram_rdata;
  logic          ram_wen, ram_ren;

  subservient_ram_arbiter #(
    .depth(Depth), .aw(Aw), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
    .o_a_gnt(a_gnt), .o_a_rvalid(a_rvalid), .o_a_rdata(a_rdata),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_b_gnt(b_gnt), .o_b_rvalid(b_rvalid), .o_b_rdata(b_rdata),
    .i_clear(clear), .o_busy(busy),
    .o_ram_waddr(ram_waddr), .o_ram_raddr(ram_raddr), .o_ram_wdata(ram_wdata),
    .o_ram_wen(ram_wen), .o_ram_ren(ram_ren), .i_ram_rdata(ram_rdata)
  );

  // Environment RAM: registered read, one cycle latency.
  logic [7:0] ram [Depth];
  always @(posedge clk) begin
    if (ram_wen) ram[ram_waddr] <= ram_wdata;
    if (ram_ren) ram_rdata <= ram[ram_raddr];
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] shadow [Depth];
  int         m_sweep;   // remaining zero-fill writes
  bit         m_last_a;  // A was the most recently granted requester
  bit         m_arv, m_brv, m_ga, m_gb;
  logic [7:0] m_ard, m_brd;
  bit         obs_ga, obs_gb, obs_arv, obs_brv, obs_busy;
  logic [7:0] obs_ard, obs_brd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge with inputs set; checks at the falling edge.
  task automatic do_cycle();
    bit            ga, gb, ewen, eren;
    logic [Aw-1:0] swa, ewa, era, owa, ora;
    logic [7:0]    ewd, owd;
    @(negedge clk);
    obs_ga  = a_gnt;    obs_gb  = b_gnt;   obs_busy = busy;
    obs_arv = a_rvalid; obs_ard = a_rdata;
    obs_brv = b_rvalid; obs_brd = b_rdata;
    ga = 1'b0; gb = 1'b0;
    if (!rst_n) begin
      check("reset_outputs", {a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata, busy,
                              ram_wen, ram_ren, ram_waddr, ram_raddr, ram_wdata}, 64'd0);
      m_arv = 1'b0; m_brv = 1'b0; m_last_a = 1'b0; m_sweep = Depth;
    end else begin
      swa = Aw'(Depth - m_sweep);
      if (m_sweep > 0) begin
        check("busy_sweep", {63'd0, busy}, 64'd1);
        check("sweep_cmd", {a_gnt, b_gnt, ram_wen, ram_ren, ram_waddr, ram_wdata},
              {1'b0, 1'b0, 1'b1, 1'b0, swa, 8'h00});
      end else begin
        if (a_req && b_req) begin
          ga = !m_last_a; gb = m_last_a;
        end else begin
          ga = a_req; gb = b_req;
        end
        ewen = 1'b0; eren = 1'b0; ewa = '0; era = '0; ewd = 8'h00;
        if (ga) begin
          if (a_we) begin ewen = 1'b1; ewa = a_addr; ewd = a_wdata; end
          else begin eren = 1'b1; era = a_addr; end
        end else if (gb) begin
          if (b_we) begin ewen = 1'b1; ewa = b_addr; ewd = b_wdata; end
          else begin eren = 1'b1; era = b_addr; end
        end
        owa = ram_wen ? ram_waddr : '0;
        owd = ram_wen ? ram_wdata : 8'h00;
        ora = ram_ren ? ram_raddr : '0;
        check("busy_run", {63'd0, busy}, 64'd0);
        check("grant", {62'd0, a_gnt, b_gnt}, {62'd0, ga, gb});
        check("ram_cmd", {ram_wen, ram_ren, owa, owd, ora}, {ewen, eren, ewa, ewd, era});
      end
      check("a_resp", {a_rvalid, a_rdata}, {m_arv, m_arv ? m_ard : 8'h00});
      check("b_resp", {b_rvalid, b_rdata}, {m_brv, m_brv ? m_brd : 8'h00});
      m_arv = 1'b0; m_brv = 1'b0;
      if (m_sweep > 0) begin
        shadow[swa] = 8'h00;
        m_sweep--;
      end else begin
        if (ga) begin
          m_last_a = 1'b1;
          if (a_we) shadow[a_addr] = a_wdata;
          else begin m_arv = 1'b1; m_ard = shadow[a_addr]; end
        end
        if (gb) begin
          m_last_a = 1'b0;
          if (b_we) shadow[b_addr] = b_wdata;
          else begin m_brv = 1'b1; m_brd = shadow[b_addr]; end
        end
        if (clear) m_sweep = Depth;
      end
    end
    m_ga = ga; m_gb = gb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit pa, pb;
    int busy_cnt;
    rst_n = 1'b0; clear = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = 8'h00;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = 8'h00;
    for (int i = 0; i < Depth; i++) shadow[i] = 8'h00;
    m_sweep = Depth; m_last_a = 1'b0; m_arv = 1'b0; m_brv = 1'b0;
    m_ard = 8'h00; m_brd = 8'h00;

    repeat (3) do_cycle();
    rst_n = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < Depth + 1; i++) begin
      do_cycle();
      if (obs_busy) busy_cnt++;
    end
    check("post_reset_sweep_len", busy_cnt, Depth);

    // A writes 0x5A to 0x10 then reads it back.
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h10; a_wdata = 8'h5A;
    do_cycle();
    a_we = 1'b0;
    do_cycle();
    a_req = 1'b0;
    do_cycle();
    check("a_readback", {obs_arv, obs_ard, obs_brv}, {1'b1, 8'h5A, 1'b0});

    // B write hands priority back to A for the alternation test.
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'h20; b_wdata = 8'hC3;
    do_cycle();
    b_we = 1'b0; a_req = 1'b1; a_addr = 8'h10;
    for (int i = 0; i < 6; i++) begin
      do_cycle();
      check("alternation", {obs_ga, obs_gb}, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    a_req = 1'b0; b_req = 1'b0;
    do_cycle();

    // Clear requested while B read is granted; its response still arrives.
    b_req = 1'b1; b_addr = 8'h20; clear = 1'b1;
    do_cycle();
    clear = 1'b0; b_req = 1'b0; a_req = 1'b1; a_addr = 8'h10;
    do_cycle();
    check("b_resp_first_clear", {obs_brv, obs_brd, obs_busy}, {1'b1, 8'hC3, 1'b1});
    busy_cnt = 1;
    for (int i = 1; i < Depth; i++) begin
      clear = (i == 50);
      do_cycle();
      if (obs_busy) busy_cnt++;
    end
    clear = 1'b0;
    check("clear_sweep_len", busy_cnt, Depth);
    do_cycle();
    check("served_after_sweep", {obs_busy, obs_ga}, {1'b0, 1'b1});
    a_req = 1'b0;
    do_cycle();
    check("zeroed_readback", {obs_arv, obs_ard}, {1'b1, 8'h00});

    // Reset with a read in flight, then reset mid-sweep at address 0x80.
    a_req = 1'b1;
    do_cycle();
    a_req = 1'b0; rst_n = 1'b0;
    do_cycle();
    rst_n = 1'b1;
    repeat (8'h80) do_cycle();
    rst_n = 1'b0;
    do_cycle();
    do_cycle();
    rst_n = 1'b1;
    do_cycle();
    check("sweep_restart", {obs_busy, ram_waddr}, {1'b1, 8'h01});
    repeat (Depth - 1) do_cycle();

    // Random traffic; requests hold their fields until granted.
    pa = 1'b0; pb = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!pa) begin
        pa = ($urandom_range(0, 2) != 0); a_we = $urandom_range(0, 1) == 1;
        a_addr = Aw'($urandom_range(0, 31)); a_wdata = 8'($urandom);
      end
      if (!pb) begin
        pb = ($urandom_range(0, 2) != 0); b_we = $urandom_range(0, 1) == 1;
        b_addr = Aw'($urandom_range(0, 31)); b_wdata = 8'($urandom);
      end
      a_req = pa; b_req = pb;
      clear = ($urandom_range(0, 499) == 0);
      do_cycle();
      if (m_ga) pa = 1'b0;
      if (m_gb) pb = 1'b0;
    end
    a_req = 1'b0; b_req = 1'b0; clear = 1'b0;
    repeat (Depth + 2) do_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
